// File: rtl/icache_sa_pkg.sv
// Shared encodings, default geometry and halfword helper for the two-way instruction cache.
package icache_sa_pkg;

    localparam int ICACHE_IDX_W  = 4;
    localparam int ICACHE_LINE_W = 2;

    typedef enum logic {
        ICACHE_ST_IDLE = 1'b0,
        ICACHE_ST_FILL = 1'b1
    } icache_st_t;

    function automatic logic [15:0] pick_half(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/icache_sa_way.sv
// One cache way: data/tag/valid arrays with two combinational read ports and one word write port.
// Reads are zero-latency; writes, valid clears and invalidates land on the edge when en is high.
module icache_way
    import icache_sa_pkg::*;
#(
    parameter int IDX_W  = ICACHE_IDX_W,
    parameter int LINE_W = ICACHE_LINE_W,
    parameter int TAG_W  = 30 - IDX_W - LINE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [IDX_W-1:0]        a_idx,
    input  logic [TAG_W-1:0]        a_tag,
    input  logic [LINE_W-1:0]       a_word,
    output logic                    a_hit,
    output logic [31:0]             a_data,
    input  logic [IDX_W-1:0]        b_idx,
    input  logic [TAG_W-1:0]        b_tag,
    input  logic [LINE_W-1:0]       b_word,
    output logic                    b_hit,
    output logic [31:0]             b_data,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [LINE_W-1:0]       wr_word,
    input  logic [31:0]             wr_data,
    input  logic                    tag_wr,
    input  logic [TAG_W-1:0]        tag_dat,
    input  logic                    set_valid,
    input  logic                    clr_en,
    input  logic [IDX_W-1:0]        clr_idx,
    input  logic                    inv,
    output logic [(1<<IDX_W)-1:0]   valid
);

    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << LINE_W;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*WORDS];

    assign a_hit  = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign a_data = data_q[{a_idx, a_word}];
    assign b_hit  = valid_q[b_idx] && (tag_q[b_idx] == b_tag);
    assign b_data = data_q[{b_idx, b_word}];
    assign valid  = valid_q;

    // Global invalidate overrides a tag write in the same cycle, so a flush racing the last beat wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (en) begin
            if (inv) begin
                valid_q <= '0;
            end else begin
                if (clr_en)
                    valid_q[clr_idx] <= 1'b0;
                if (tag_wr)
                    valid_q[wr_idx] <= set_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && wr_en)
            data_q[{wr_idx, wr_word}] <= wr_data;
        if (en && tag_wr)
            tag_q[wr_idx] <= tag_dat;
    end

endmodule

// File: rtl/icache_sa.sv
// Two-way set-associative instruction cache returning 16/32-bit instructions at any halfword PC.
// Hits are combinational; misses run a line refill burst; rdy_in low freezes all state.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int IDX_W  = ICACHE_IDX_W,
    parameter int LINE_W = ICACHE_LINE_W,
    parameter int TAG_W  = 30 - IDX_W - LINE_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] addr_in,
    input  logic        flush,
    output logic        cache_hit,
    output logic [31:0] data_out,
    output logic        inst_length,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        busy
);

    localparam int SETS = 1 << IDX_W;
    localparam int LA_W = 30 - LINE_W;

    icache_st_t        state_q, state_nxt;
    logic [LA_W-1:0]   fill_la_q;
    logic              victim_q;
    logic [LINE_W-1:0] beat_q;
    logic              dead_q;
    logic [SETS-1:0]   lru_q;

    logic              start, wr_beat, last;
    logic              victim_nxt;
    logic [LA_W-1:0]   miss_la;
    logic [IDX_W-1:0]  miss_idx;

    // Halfword addresses of the two instruction halves; H2 may fall in the next line.
    logic [30:0]      h1_ha, h2_ha;
    logic [LA_W-1:0]  h1_la, h2_la;
    logic             unused_lsb;

    assign unused_lsb = addr_in[0];
    assign h1_ha      = addr_in[31:1];
    assign h2_ha      = h1_ha + 31'd1;
    assign h1_la      = h1_ha[30:LINE_W+1];
    assign h2_la      = h2_ha[30:LINE_W+1];

    logic [1:0]      a_hit, b_hit;
    logic [31:0]     a_dat [2];
    logic [31:0]     b_dat [2];
    logic [SETS-1:0] way_valid [2];
    logic            h1_hit, h2_hit, is32;
    logic [31:0]     h1_word, h2_word;
    logic [15:0]     h1_half, h2_half;

    for (genvar w = 0; w < 2; w++) begin : g_way
        icache_way #(.IDX_W(IDX_W), .LINE_W(LINE_W), .TAG_W(TAG_W)) u_way (
            .clk       (clk_in),
            .rst       (rst_in),
            .en        (rdy_in),
            .a_idx     (h1_la[IDX_W-1:0]),
            .a_tag     (h1_la[LA_W-1:IDX_W]),
            .a_word    (h1_ha[LINE_W:1]),
            .a_hit     (a_hit[w]),
            .a_data    (a_dat[w]),
            .b_idx     (h2_la[IDX_W-1:0]),
            .b_tag     (h2_la[LA_W-1:IDX_W]),
            .b_word    (h2_ha[LINE_W:1]),
            .b_hit     (b_hit[w]),
            .b_data    (b_dat[w]),
            .wr_en     (wr_beat && (victim_q == w[0])),
            .wr_idx    (fill_la_q[IDX_W-1:0]),
            .wr_word   (beat_q),
            .wr_data   (mem_data),
            .tag_wr    (last && (victim_q == w[0])),
            .tag_dat   (fill_la_q[LA_W-1:IDX_W]),
            .set_valid (!dead_q && !flush),
            .clr_en    (start && (victim_nxt == w[0])),
            .clr_idx   (miss_idx),
            .inv       (flush),
            .valid     (way_valid[w])
        );
    end

    assign h1_hit    = |a_hit;
    assign h2_hit    = |b_hit;
    assign h1_word   = a_hit[1] ? a_dat[1] : a_dat[0];
    assign h2_word   = b_hit[1] ? b_dat[1] : b_dat[0];
    assign h1_half   = pick_half(h1_word, h1_ha[0]);
    assign h2_half   = pick_half(h2_word, h2_ha[0]);
    assign is32      = (h1_half[1:0] == 2'b11);

    assign cache_hit   = h1_hit && (!is32 || h2_hit);
    assign inst_length = cache_hit && is32;
    assign data_out    = !cache_hit ? 32'd0 : (is32 ? {h2_half, h1_half} : {16'd0, h1_half});

    // When H1 is present the miss must be on the H2 line.
    assign miss_la    = h1_hit ? h2_la : h1_la;
    assign miss_idx   = miss_la[IDX_W-1:0];
    assign victim_nxt = !way_valid[0][miss_idx] ? 1'b0 :
                        !way_valid[1][miss_idx] ? 1'b1 : lru_q[miss_idx];

    assign mem_req  = (state_q == ICACHE_ST_FILL);
    assign busy     = (state_q != ICACHE_ST_IDLE);
    assign mem_addr = mem_req ? {fill_la_q, {(LINE_W+2){1'b0}}} : 32'd0;

    always_comb begin
        state_nxt = state_q;
        start     = 1'b0;
        wr_beat   = 1'b0;
        last      = 1'b0;
        case (state_q)
            ICACHE_ST_IDLE: begin
                if (!cache_hit && !flush) begin
                    state_nxt = ICACHE_ST_FILL;
                    start     = 1'b1;
                end
            end
            ICACHE_ST_FILL: begin
                if (mem_valid) begin
                    wr_beat = 1'b1;
                    if (beat_q == {LINE_W{1'b1}}) begin
                        last      = 1'b1;
                        state_nxt = ICACHE_ST_IDLE;
                    end
                end
            end
            default: state_nxt = ICACHE_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ICACHE_ST_IDLE;
            fill_la_q <= '0;
            victim_q  <= 1'b0;
            beat_q    <= '0;
            dead_q    <= 1'b0;
            lru_q     <= '0;
        end else if (rdy_in) begin
            state_q <= state_nxt;
            if (start) begin
                fill_la_q <= miss_la;
                victim_q  <= victim_nxt;
                beat_q    <= '0;
            end
            if (wr_beat)
                beat_q <= beat_q + 1'b1;
            // A flush during a burst lets it finish but keeps the line from being validated.
            if (state_nxt == ICACHE_ST_IDLE)
                dead_q <= 1'b0;
            else if (flush)
                dead_q <= 1'b1;
            if (flush)
                lru_q <= '0;
            else if (state_q == ICACHE_ST_IDLE && cache_hit)
                lru_q[h1_la[IDX_W-1:0]] <= !a_hit[1];
        end
    end

endmodule
